qick_bit2vec: RTL and testbench
===============================

Name: qick_bit2vec

Overview:
- Gathers up to 16 discrete single-bit signals into one vector. These can be trigger lines, PMOD inputs or marker returns from other cores.
- Synchronises each bit to clk_i and detects any change across the vector.
- Delivers each changed snapshot on an AXI-Stream-style valid/ready output. Snapshots dropped under backpressure are counted.
- Sits at the edge of the QICK fabric, opposite the vector-to-bit splitter. It is the collection path back into tProcessor/readout logic.

Parameters:
- OUT_DW, 16, number of active bits (1..16); din inputs at or above OUT_DW are ignored, and upper tdata bits read 0.
- SYNC_STAGES, 2, flip-flop stages per bit in the synchroniser (2..4).
- CNT_DW, 16, width of the lost-snapshot counter.

Ports:
- clk_i  in  1  single block clock.
- rst_ni  in  1  asynchronous active-low reset; deassertion synchronous to clk_i.
- en_i  in  1  event generation enable (already in the clk_i domain).
- din0..din15  in  1 each  asynchronous bit inputs; din<k> maps to vector bit k.
- dout_o  out  16  continuous synchronised vector, no handshake.
- dout_tdata  out  16  captured snapshot.
- dout_tvalid  out  1  snapshot valid.
- dout_tready  in  1  downstream ready.
- lost_cnt_o  out  CNT_DW  saturating count of overwritten snapshots.
- clr_lost_i  in  1  synchronous clear of lost_cnt_o.

Behaviour:
- Reset values: dout_o, dout_tdata, dout_tvalid and lost_cnt_o all reset to 0. Internal previous-vector register resets to 0. Pending flag and pending data reset to 0. FSM resets to IDLE.
- Synchroniser:
  - Each active bit passes through SYNC_STAGES flops. The last stage drives dout_o.
- Change detect:
  - chg = (sync != prev) & en_i. prev <= sync every cycle, whether or not en_i is set.
  - Changes while en_i=0 are therefore absorbed, and enabling never emits a stale event.
  - Any input bit that is high when reset releases produces one event once enabled through the detect path.
- Latency: dout_tvalid rises SYNC_STAGES+1 clk_i edges after the first edge that samples the new din level. dout_tdata equals that sync vector.
- FSM, 2 states:
  - IDLE: dout_tvalid=0. On chg, load tdata <= sync, go to VALID.
  - VALID: dout_tvalid=1. tdata is held stable while tready=0 (AXIS rule).
    - chg & !tready: pend_data <= sync and pend <= 1. If pend was already 1, increment lost_cnt.
    - tready & !chg & pend: tdata <= pend_data, pend <= 0, stay in VALID.
    - tready & !chg & !pend: go to IDLE.
    - tready & chg: tdata <= sync (newest supersedes pending), stay in VALID. If pend=1, increment lost_cnt and clear pend.
- Backpressure storage: at most one pending snapshot beyond tdata. Only the most recent change is kept.
- lost_cnt:
  - Saturates at all-ones; it never wraps.
  - When clr_lost_i and an increment occur in the same cycle, the counter ends at 0. Clear has priority.
- en_i deasserted in VALID: the current tdata and any pend still drain. Only new detection stops.
- Reset mid-operation:
  - All state clears immediately and asynchronously. dout_tvalid drops with no handshake.
  - Synchroniser flops also clear, so dout_o reads 0 until SYNC_STAGES edges after release.
- Glitches:
  - A din pulse shorter than one clk_i period may be missed. This is by design.
  - A pulse of two or more periods always produces an event (with en_i=1).

Optional Feature:
- Macro: QICK_BIT2VEC_TSTAMP_EN.
- Defined:
  - Adds a free-running 32-bit timestamp counter, reset to 0, that wraps.
  - Adds output port dout_tuser[31:0]. It carries the counter value on the cycle chg was detected, and is captured and held alongside tdata/pend_data.
  - A pending snapshot keeps its own timestamp.
- Undefined: no counter and no dout_tuser port; all other behaviour is identical.

Test Plan:
- Reset, then en_i=1, tready=1, din3 goes 0->1 -> tvalid pulses for 1 cycle at edge SYNC_STAGES+1, with tdata=0x0008; dout_o=0x0008.
- tready=0, then din0 rises, then din1 rises, then din2 rises, each 5 cycles apart -> tdata holds 0x0001 and lost_cnt=1. On tready=1, the next transfer delivers 0x0007, then tvalid falls.
- en_i=0, din changes to 0x00F0, then en_i=1 with no further change -> no tvalid; dout_o=0x00F0.
- tready high in the same cycle a new change is detected while pend=1 -> tdata updates to the newest vector and lost_cnt increments by exactly 1.
- Force 2^CNT_DW+3 overwrites -> lost_cnt holds 0xFFFF. Pulse clr_lost_i together with an overwrite -> lost_cnt=0.
- Assert rst_ni low while tvalid=1 and pend=1 -> all outputs read 0 immediately. After release with din unchanged at 0x0005, one event with tdata=0x0005 is emitted.

Source files
------------

// File: rtl/qick_bit2vec.sv
// qick_bit2vec: gathers up to 16 asynchronous bits into one synchronised vector and
// streams every changed snapshot over valid/ready. Optional timestamp: QICK_BIT2VEC_TSTAMP_EN.
module qick_bit2vec #(
  parameter int OUT_DW      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_DW      = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              din0,
  input  logic              din1,
  input  logic              din2,
  input  logic              din3,
  input  logic              din4,
  input  logic              din5,
  input  logic              din6,
  input  logic              din7,
  input  logic              din8,
  input  logic              din9,
  input  logic              din10,
  input  logic              din11,
  input  logic              din12,
  input  logic              din13,
  input  logic              din14,
  input  logic              din15,
  output logic [15:0]       dout_o,
  output logic [15:0]       dout_tdata,
  output logic              dout_tvalid,
  input  logic              dout_tready,
  output logic [CNT_DW-1:0] lost_cnt_o,
  input  logic              clr_lost_i
`ifdef QICK_BIT2VEC_TSTAMP_EN
  ,
  output logic [31:0]       dout_tuser
`endif
);

  localparam logic [15:0] ACT_MASK = 16'hFFFF >> (16 - OUT_DW);

  typedef enum logic {IDLE = 1'b0, VALID = 1'b1} state_t;

  logic [15:0]       din_s;
  logic [15:0]       sync_r [SYNC_STAGES];
  logic [15:0]       sync_s;
  logic [15:0]       prev_r;
  logic              chg_s;
  state_t            state_r, state_n;
  logic              tvalid_r;
  logic [15:0]       tdata_r;
  logic              pend_r, pend_n;
  logic [15:0]       pdata_r;
  logic              load_sync_s, load_pend_s, cap_pend_s, lost_inc_s;
  logic [CNT_DW-1:0] lost_r;

  assign din_s = {din15, din14, din13, din12, din11, din10, din9, din8,
                  din7, din6, din5, din4, din3, din2, din1, din0} & ACT_MASK;

  // synchroniser chain; inactive lanes are masked to constant zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 16'h0000;
    end else begin
      sync_r[0] <= din_s;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];
  assign dout_o = sync_s;

  // prev tracks sync unconditionally so changes seen while disabled are absorbed
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_r <= 16'h0000;
    else         prev_r <= sync_s;
  end

  assign chg_s = (sync_s != prev_r) && en_i;

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= IDLE;
      tvalid_r <= 1'b0;
    end else begin
      state_r  <= state_n;
      tvalid_r <= (state_n == VALID);
    end
  end

  // next state and datapath steering; newest change always supersedes a pending one
  always_comb begin
    state_n     = state_r;
    pend_n      = pend_r;
    load_sync_s = 1'b0;
    load_pend_s = 1'b0;
    cap_pend_s  = 1'b0;
    lost_inc_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (chg_s) begin
          load_sync_s = 1'b1;
          state_n     = VALID;
        end else begin
          state_n = IDLE;
        end
      end
      VALID: begin
        if (dout_tready) begin
          if (chg_s) begin
            load_sync_s = 1'b1;
            lost_inc_s  = pend_r;
            pend_n      = 1'b0;
          end else if (pend_r) begin
            load_pend_s = 1'b1;
            pend_n      = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          if (chg_s) begin
            cap_pend_s = 1'b1;
            pend_n     = 1'b1;
            lost_inc_s = pend_r;
          end else begin
            pend_n = pend_r;
          end
        end
      end
      default: begin
        state_n = IDLE;
        pend_n  = 1'b0;
      end
    endcase
  end

  // snapshot and pending-slot registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tdata_r <= 16'h0000;
      pdata_r <= 16'h0000;
      pend_r  <= 1'b0;
    end else begin
      pend_r <= pend_n;
      if (load_sync_s)      tdata_r <= sync_s;
      else if (load_pend_s) tdata_r <= pdata_r;
      else                  tdata_r <= tdata_r;
      if (cap_pend_s) pdata_r <= sync_s;
      else            pdata_r <= pdata_r;
    end
  end

  // saturating lost-snapshot counter; clear wins over a same-cycle increment
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                     lost_r <= {CNT_DW{1'b0}};
    else if (clr_lost_i)                             lost_r <= {CNT_DW{1'b0}};
    else if (lost_inc_s && (lost_r != {CNT_DW{1'b1}})) lost_r <= lost_r + CNT_DW'(1);
    else                                             lost_r <= lost_r;
  end

  assign dout_tvalid = tvalid_r;
  assign dout_tdata  = tdata_r;
  assign lost_cnt_o  = lost_r;

`ifdef QICK_BIT2VEC_TSTAMP_EN
  logic [31:0] ts_r, tuser_r, puser_r;

  // free-running timestamp; each slot carries the stamp of the cycle its change was detected
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ts_r    <= 32'h0000_0000;
      tuser_r <= 32'h0000_0000;
      puser_r <= 32'h0000_0000;
    end else begin
      ts_r <= ts_r + 32'd1;
      if (load_sync_s)      tuser_r <= ts_r;
      else if (load_pend_s) tuser_r <= puser_r;
      else                  tuser_r <= tuser_r;
      if (cap_pend_s) puser_r <= ts_r;
      else            puser_r <= puser_r;
    end
  end

  assign dout_tuser = tuser_r;
`endif

endmodule

// File: tb/tb_qick_bit2vec.sv
// Self-checking bench for qick_bit2vec: directed scenarios plus randomized traffic,
// all compared each cycle against a snapshot-queue reference model.
`timescale 1ns/1ps
module tb_qick_bit2vec;

  localparam int OUT_DW      = 16;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_DW      = 16;
  localparam logic [15:0] MASK = 16'hFFFF >> (16 - OUT_DW);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [15:0]       din;
  logic              tready;
  logic              clr;
  logic [15:0]       dout_o;
  logic [15:0]       dout_tdata;
  logic              dout_tvalid;
  logic [CNT_DW-1:0] lost_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: m_q holds snapshots, m_q[0] is the one on the bus
  logic [15:0] m_q[$];
  logic [15:0] m_dl[$];
  logic [15:0] m_sync;
  logic [15:0] m_prev;
  logic [15:0] m_lost;

  always #5 clk = ~clk;

  qick_bit2vec #(.OUT_DW(OUT_DW), .SYNC_STAGES(SYNC_STAGES), .CNT_DW(CNT_DW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en),
    .din0(din[0]),   .din1(din[1]),   .din2(din[2]),   .din3(din[3]),
    .din4(din[4]),   .din5(din[5]),   .din6(din[6]),   .din7(din[7]),
    .din8(din[8]),   .din9(din[9]),   .din10(din[10]), .din11(din[11]),
    .din12(din[12]), .din13(din[13]), .din14(din[14]), .din15(din[15]),
    .dout_o(dout_o), .dout_tdata(dout_tdata), .dout_tvalid(dout_tvalid),
    .dout_tready(tready), .lost_cnt_o(lost_cnt), .clr_lost_i(clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_dl.delete();
    for (int i = 0; i < SYNC_STAGES - 1; i++) m_dl.push_back(16'h0000);
    m_sync = 16'h0000;
    m_prev = 16'h0000;
    m_lost = 16'h0000;
  endfunction

  function automatic void model_step();
    bit chg;
    bit acc;
    int keep;
    int drops;
    chg   = (m_sync != m_prev) && en;
    acc   = (m_q.size() > 0) && tready;
    drops = 0;
    if (acc) void'(m_q.pop_front());
    if (chg) begin
      // only a snapshot still on the bus survives; anything not yet presented is lost
      keep = (!acc && m_q.size() > 0) ? 1 : 0;
      while (m_q.size() > keep) begin
        void'(m_q.pop_back());
        drops++;
      end
      m_q.push_back(m_sync);
    end
    if (clr) m_lost = 16'h0000;
    else if (drops > 0 && m_lost != 16'hFFFF) m_lost = m_lost + 16'd1;
    m_prev = m_sync;
    m_dl.push_back(din & MASK);
    m_sync = m_dl.pop_front();
  endfunction

  task automatic compare();
    chk("dout_o", {16'h0000, dout_o}, {16'h0000, m_sync});
    chk("tvalid", {31'd0, dout_tvalid}, {31'd0, (m_q.size() > 0)});
    if (m_q.size() > 0) chk("tdata", {16'h0000, dout_tdata}, {16'h0000, m_q[0]});
    chk("lost_cnt", {16'h0000, lost_cnt}, {16'h0000, m_lost});
  endtask

  // one clock: model follows the active edge, DUT is compared on the falling edge
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset(input logic [15:0] v);
    rst_n = 1'b0;
    din   = v;
    clr   = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int cyc;
    int extra;
    logic seen;
    rst_n  = 1'b0;
    en     = 1'b0;
    din    = 16'h0000;
    tready = 1'b0;
    clr    = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("rst_dout_o", {16'h0000, dout_o}, 32'h0);
    chk("rst_tvalid", {31'd0, dout_tvalid}, 32'h0);
    chk("rst_tdata", {16'h0000, dout_tdata}, 32'h0);
    chk("rst_lost", {16'h0000, lost_cnt}, 32'h0);
    rst_n = 1'b1;

    // single bit rise: event on the third edge, one-cycle pulse with tready high
    en = 1'b1; tready = 1'b1;
    tick(); tick();
    din = 16'h0008;
    tick();
    chk("t1_e1_tvalid", {31'd0, dout_tvalid}, 32'h0);
    tick();
    chk("t1_e2_dout_o", {16'h0000, dout_o}, 32'h8);
    chk("t1_e2_tvalid", {31'd0, dout_tvalid}, 32'h0);
    tick();
    chk("t1_e3_tvalid", {31'd0, dout_tvalid}, 32'h1);
    chk("t1_e3_tdata", {16'h0000, dout_tdata}, 32'h8);
    tick();
    chk("t1_e4_tvalid", {31'd0, dout_tvalid}, 32'h0);

    // backpressure: three rises, middle one overwritten
    do_reset(16'h0000);
    en = 1'b1; tready = 1'b0;
    din = 16'h0001; repeat (5) tick();
    din = 16'h0003; repeat (5) tick();
    din = 16'h0007; repeat (5) tick();
    chk("t2_tdata_held", {16'h0000, dout_tdata}, 32'h1);
    chk("t2_lost", {16'h0000, lost_cnt}, 32'h1);
    tready = 1'b1;
    tick();
    chk("t2_next_tdata", {16'h0000, dout_tdata}, 32'h7);
    chk("t2_next_tvalid", {31'd0, dout_tvalid}, 32'h1);
    tick();
    chk("t2_drained", {31'd0, dout_tvalid}, 32'h0);

    // changes while disabled are absorbed
    do_reset(16'h0000);
    en = 1'b0; tready = 1'b1;
    din = 16'h00F0; repeat (5) tick();
    en = 1'b1; seen = 1'b0;
    repeat (6) begin tick(); seen = seen | dout_tvalid; end
    chk("t3_no_event", {31'd0, seen}, 32'h0);
    chk("t3_dout_o", {16'h0000, dout_o}, 32'hF0);

    // tready coincides with a new change while a snapshot is pending
    do_reset(16'h0000);
    en = 1'b1; tready = 1'b0;
    din = 16'h0001; repeat (5) tick();
    din = 16'h0003; repeat (5) tick();
    chk("t4_lost_before", {16'h0000, lost_cnt}, 32'h0);
    din = 16'h0007;
    tick(); tick();
    tready = 1'b1;
    tick();
    tready = 1'b0;
    chk("t4_tdata_newest", {16'h0000, dout_tdata}, 32'h7);
    chk("t4_lost_plus1", {16'h0000, lost_cnt}, 32'h1);

    // saturation, then clear colliding with an overwrite
    do_reset(16'h0000);
    en = 1'b1; tready = 1'b0;
    for (int i = 0; i < 65545; i++) begin din[0] = ~din[0]; tick(); end
    chk("t5_saturated", {16'h0000, lost_cnt}, 32'hFFFF);
    clr = 1'b1; din[0] = ~din[0]; tick();
    chk("t5_clr_sat", {16'h0000, lost_cnt}, 32'h0);
    clr = 1'b0; din[0] = ~din[0]; tick();
    chk("t5_inc_after_clr", {16'h0000, lost_cnt}, 32'h1);
    clr = 1'b1; din[0] = ~din[0]; tick();
    chk("t5_clr_wins", {16'h0000, lost_cnt}, 32'h0);
    clr = 1'b0;

    // asynchronous reset with a snapshot valid and one pending
    do_reset(16'h0000);
    en = 1'b1; tready = 1'b0;
    din = 16'h0001; repeat (5) tick();
    din = 16'h0003; repeat (5) tick();
    din = 16'h0005; repeat (4) tick();
    chk("t6_tvalid_pre", {31'd0, dout_tvalid}, 32'h1);
    chk("t6_lost_pre", {16'h0000, lost_cnt}, 32'h1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_async_dout_o", {16'h0000, dout_o}, 32'h0);
    chk("t6_async_tvalid", {31'd0, dout_tvalid}, 32'h0);
    chk("t6_async_tdata", {16'h0000, dout_tdata}, 32'h0);
    chk("t6_async_lost", {16'h0000, lost_cnt}, 32'h0);
    tick(); tick();
    rst_n = 1'b1; tready = 1'b1;
    cyc = 0;
    tick();
    while (!dout_tvalid && cyc < 20) begin tick(); cyc++; end
    chk("t6_event_seen", {31'd0, dout_tvalid}, 32'h1);
    chk("t6_event_tdata", {16'h0000, dout_tdata}, 32'h5);
    extra = 0;
    repeat (10) begin tick(); if (dout_tvalid) extra++; end
    chk("t6_single_event", extra, 0);

    // randomized traffic against the model
    do_reset(16'h0000);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3, 0) == 0) begin
        if ($urandom_range(1, 0) == 0) din = 16'($urandom);
        else din[$urandom_range(15, 0)] = ~din[$urandom_range(15, 0)];
      end
      en     = ($urandom_range(7, 0) != 0);
      tready = ($urandom_range(2, 0) != 0);
      clr    = ($urandom_range(49, 0) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
